// File: rtl/cdb_pkg.sv
// Shared widths, source indices and entry type for the CDB arbiter slice.
// Optional round-robin arbitration is enabled with the CDB_RR_ARB_EN macro.
package cdb_pkg;

    localparam int CDB_PREG_W = 5;
    localparam int CDB_DATA_W = 32;
    localparam int NUM_SRC    = 3;

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_MUL = 2'd1;
    localparam logic [1:0] SRC_LSU = 2'd2;

    typedef struct packed {
        logic [CDB_PREG_W-1:0] prd;
        logic [CDB_DATA_W-1:0] value;
    } cdb_entry_t;

    // Source index k positions after src, wrapping over the three sources.
    function automatic logic [1:0] src_after(input logic [1:0] src, input int k);
        return 2'((int'(src) + k) % NUM_SRC);
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Writeback inputs from ALU/MUL/LSU and the CDB broadcast outputs.
// Handshake: a result transfers on a rising edge where *_wb_valid_i && *_wb_ready_o.
interface cdb_arbiter_if
    import cdb_pkg::*;
#(
    parameter int PREG_W = CDB_PREG_W,
    parameter int DATA_W = CDB_DATA_W
);

    logic              alu_wb_valid_i;
    logic [PREG_W-1:0] alu_wb_prd_i;
    logic [DATA_W-1:0] alu_wb_value_i;
    logic              alu_wb_ready_o;

    logic              mul_wb_valid_i;
    logic [PREG_W-1:0] mul_wb_prd_i;
    logic [DATA_W-1:0] mul_wb_value_i;
    logic              mul_wb_ready_o;

    logic              lsu_wb_valid_i;
    logic [PREG_W-1:0] lsu_wb_prd_i;
    logic [DATA_W-1:0] lsu_wb_value_i;
    logic              lsu_wb_ready_o;

    logic              cdb_en_o;
    logic [PREG_W-1:0] cdb_reg_addr_o;
    logic [DATA_W-1:0] cdb_data_o;
    logic [1:0]        cdb_src_o;

    modport slave (
        input  alu_wb_valid_i, alu_wb_prd_i, alu_wb_value_i,
        input  mul_wb_valid_i, mul_wb_prd_i, mul_wb_value_i,
        input  lsu_wb_valid_i, lsu_wb_prd_i, lsu_wb_value_i,
        output alu_wb_ready_o, mul_wb_ready_o, lsu_wb_ready_o,
        output cdb_en_o, cdb_reg_addr_o, cdb_data_o, cdb_src_o
    );

    modport master (
        output alu_wb_valid_i, alu_wb_prd_i, alu_wb_value_i,
        output mul_wb_valid_i, mul_wb_prd_i, mul_wb_value_i,
        output lsu_wb_valid_i, lsu_wb_prd_i, lsu_wb_value_i,
        input  alu_wb_ready_o, mul_wb_ready_o, lsu_wb_ready_o,
        input  cdb_en_o, cdb_reg_addr_o, cdb_data_o, cdb_src_o
    );

endinterface

// File: rtl/cdb_src_fifo.sv
// Per-source circular result queue; full/empty come from the registered count only.
module cdb_src_fifo #(
    parameter int W      = 37,
    parameter int QDEPTH = 2
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(QDEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointers wrap naturally because QDEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Serialises ALU/MUL/LSU writebacks onto the single registered CDB broadcast.
// Fixed priority LSU > MUL > ALU; round-robin when CDB_RR_ARB_EN is defined.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int PREG_W = CDB_PREG_W,
    parameter int DATA_W = CDB_DATA_W,
    parameter int QDEPTH = 2
) (
    input  logic          clk_i,
    input  logic          reset_i,
    cdb_arbiter_if.slave  bus
);

    localparam int ENTRY_W = PREG_W + DATA_W;

    logic               in_valid [NUM_SRC];
    logic [PREG_W-1:0]  in_prd   [NUM_SRC];
    logic [ENTRY_W-1:0] in_entry [NUM_SRC];
    logic               push     [NUM_SRC];
    logic               pop      [NUM_SRC];
    logic               full     [NUM_SRC];
    logic               empty    [NUM_SRC];
    logic [ENTRY_W-1:0] head     [NUM_SRC];

    logic               grant_valid;
    logic [1:0]         grant_idx;

    logic               cdb_en_q;
    logic [PREG_W-1:0]  cdb_addr_q;
    logic [DATA_W-1:0]  cdb_data_q;
    logic [1:0]         cdb_src_q;

    assign in_valid[SRC_ALU] = bus.alu_wb_valid_i;
    assign in_valid[SRC_MUL] = bus.mul_wb_valid_i;
    assign in_valid[SRC_LSU] = bus.lsu_wb_valid_i;
    assign in_prd[SRC_ALU]   = bus.alu_wb_prd_i;
    assign in_prd[SRC_MUL]   = bus.mul_wb_prd_i;
    assign in_prd[SRC_LSU]   = bus.lsu_wb_prd_i;
    assign in_entry[SRC_ALU] = {bus.alu_wb_prd_i, bus.alu_wb_value_i};
    assign in_entry[SRC_MUL] = {bus.mul_wb_prd_i, bus.mul_wb_value_i};
    assign in_entry[SRC_LSU] = {bus.lsu_wb_prd_i, bus.lsu_wb_value_i};

    assign bus.alu_wb_ready_o = !full[SRC_ALU];
    assign bus.mul_wb_ready_o = !full[SRC_MUL];
    assign bus.lsu_wb_ready_o = !full[SRC_LSU];

    // prd 0 is accepted by the handshake but never enqueued.
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        assign push[s] = in_valid[s] && !full[s] && (in_prd[s] != '0);
        assign pop[s]  = grant_valid && (grant_idx == 2'(s));

        cdb_src_fifo #(
            .W      (ENTRY_W),
            .QDEPTH (QDEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .push_i  (push[s]),
            .data_i  (in_entry[s]),
            .pop_i   (pop[s]),
            .full_o  (full[s]),
            .empty_o (empty[s]),
            .head_o  (head[s])
        );
    end

`ifdef CDB_RR_ARB_EN
    logic [1:0] last_q;

    // Scan from the lowest-priority candidate up; the last hit wins, so
    // the source right after the previous grant is preferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = SRC_ALU;
        for (int k = NUM_SRC; k >= 1; k--) begin
            if (!empty[src_after(last_q, k)]) begin
                grant_valid = 1'b1;
                grant_idx   = src_after(last_q, k);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_q <= SRC_ALU;
        end else if (grant_valid) begin
            last_q <= grant_idx;
        end
    end
`else
    // Ascending scan, last hit wins: LSU > MUL > ALU.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = SRC_ALU;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (!empty[s]) begin
                grant_valid = 1'b1;
                grant_idx   = 2'(s);
            end
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cdb_en_q   <= 1'b0;
            cdb_addr_q <= '0;
            cdb_data_q <= '0;
            cdb_src_q  <= SRC_ALU;
        end else begin
            cdb_en_q <= grant_valid;
            if (grant_valid) begin
                cdb_addr_q <= head[grant_idx][ENTRY_W-1 -: PREG_W];
                cdb_data_q <= head[grant_idx][DATA_W-1:0];
                cdb_src_q  <= grant_idx;
            end
        end
    end

    assign bus.cdb_en_o       = cdb_en_q;
    assign bus.cdb_reg_addr_o = cdb_addr_q;
    assign bus.cdb_data_o     = cdb_data_q;
    assign bus.cdb_src_o      = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic against a
// queue-based reference model of the per-source queues and arbitration.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int PREG_W  = CDB_PREG_W;
  localparam int DATA_W  = CDB_DATA_W;
  localparam int QDEPTH  = 2;
  localparam int ENTRY_W = PREG_W + DATA_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.PREG_W(PREG_W), .DATA_W(DATA_W)) bus ();

  cdb_arbiter #(.PREG_W(PREG_W), .DATA_W(DATA_W), .QDEPTH(QDEPTH)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  // reference model state
  logic [ENTRY_W-1:0] exp_q [NUM_SRC][$];
  int                 m_last = 0;
  logic               exp_en = 1'b0;
  logic [PREG_W-1:0]  exp_addr = '0;
  logic [DATA_W-1:0]  exp_data = '0;
  logic [1:0]         exp_src = 2'd0;

  // driver state
  logic               cur_v [NUM_SRC];
  logic [PREG_W-1:0]  cur_p [NUM_SRC];
  logic [DATA_W-1:0]  cur_d [NUM_SRC];
  logic               last_acc [NUM_SRC];

  // observed broadcast log
  int bc_src_q [$];
  int bc_addr_q [$];

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic get_ready(input int s);
    case (s)
      0: return bus.alu_wb_ready_o;
      1: return bus.mul_wb_ready_o;
      default: return bus.lsu_wb_ready_o;
    endcase
  endfunction

  task automatic drive();
    bus.alu_wb_valid_i = cur_v[0]; bus.alu_wb_prd_i = cur_p[0]; bus.alu_wb_value_i = cur_d[0];
    bus.mul_wb_valid_i = cur_v[1]; bus.mul_wb_prd_i = cur_p[1]; bus.mul_wb_value_i = cur_d[1];
    bus.lsu_wb_valid_i = cur_v[2]; bus.lsu_wb_prd_i = cur_p[2]; bus.lsu_wb_value_i = cur_d[2];
  endtask

  task automatic set_src(input int s, input logic v, input int p, input logic [DATA_W-1:0] d);
    cur_v[s] = v;
    cur_p[s] = PREG_W'(p);
    cur_d[s] = d;
    drive();
  endtask

  task automatic idle_all();
    for (int s = 0; s < NUM_SRC; s++) begin
      cur_v[s] = 1'b0; cur_p[s] = '0; cur_d[s] = '0; last_acc[s] = 1'b0;
    end
    drive();
  endtask

  // Which source the arbiter should grant, from the queued contents alone.
  function automatic int pick_src();
    int best = -1;
`ifdef CDB_RR_ARB_EN
    int best_rank = NUM_SRC;
    for (int s = 0; s < NUM_SRC; s++) begin
      int rank = (s - m_last + 2) % NUM_SRC;
      if (exp_q[s].size() > 0 && rank < best_rank) begin
        best = s;
        best_rank = rank;
      end
    end
`else
    int order [3] = '{2, 1, 0};
    for (int i = 0; i < 3; i++) begin
      if (best < 0 && exp_q[order[i]].size() > 0) best = order[i];
    end
`endif
    return best;
  endfunction

  // One clock: check readies, predict the edge, check the CDB after it.
  task automatic step();
    int g;
    logic acc [NUM_SRC];
    logic [ENTRY_W-1:0] e;
    for (int s = 0; s < NUM_SRC; s++) begin
      check_val($sformatf("ready_src%0d", s), get_ready(s), exp_q[s].size() < QDEPTH);
      acc[s] = cur_v[s] && (exp_q[s].size() < QDEPTH);
    end
    g = pick_src();
    @(posedge clk);
    #1;
    if (g >= 0) begin
      e = exp_q[g].pop_front();
      exp_en = 1'b1;
      exp_addr = e[ENTRY_W-1 -: PREG_W];
      exp_data = e[DATA_W-1:0];
      exp_src = 2'(g);
      m_last = g;
    end else begin
      exp_en = 1'b0;
    end
    for (int s = 0; s < NUM_SRC; s++) begin
      if (acc[s] && cur_p[s] != '0) exp_q[s].push_back({cur_p[s], cur_d[s]});
      last_acc[s] = acc[s];
    end
    check_val("cdb_en", bus.cdb_en_o, exp_en);
    check_val("cdb_addr", bus.cdb_reg_addr_o, exp_addr);
    check_val("cdb_data", bus.cdb_data_o, exp_data);
    check_val("cdb_src", bus.cdb_src_o, exp_src);
    if (bus.cdb_en_o === 1'b1) begin
      bc_src_q.push_back(int'(bus.cdb_src_o));
      bc_addr_q.push_back(int'(bus.cdb_reg_addr_o));
    end
  endtask

  task automatic do_reset(input int n);
    idle_all();
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) exp_q[s].delete();
    m_last = 0;
    exp_en = 1'b0; exp_addr = '0; exp_data = '0; exp_src = 2'd0;
    check_val("rst_en", bus.cdb_en_o, 0);
    check_val("rst_addr", bus.cdb_reg_addr_o, 0);
    check_val("rst_data", bus.cdb_data_o, 0);
    check_val("rst_src", bus.cdb_src_o, 0);
    check_val("rst_ready_alu", bus.alu_wb_ready_o, 1);
    check_val("rst_ready_mul", bus.mul_wb_ready_o, 1);
    check_val("rst_ready_lsu", bus.lsu_wb_ready_o, 1);
  endtask

  // Random source traffic, holding a rejected result stable.
  task automatic rand_drive(input int pct);
    for (int s = 0; s < NUM_SRC; s++) begin
      if (!(cur_v[s] && !last_acc[s])) begin
        cur_v[s] = ($urandom_range(0, 99) < pct);
        cur_p[s] = PREG_W'($urandom_range(0, (1 << PREG_W) - 1));
        cur_d[s] = $urandom;
      end
    end
    drive();
  endtask

  task automatic clear_log();
    bc_src_q.delete();
    bc_addr_q.delete();
  endtask

  initial begin
    int k;
    int pct;
    logic saw_low;
    idle_all();
    do_reset(3);

    // single ALU result, broadcast two cycles after valid
    clear_log();
    set_src(0, 1'b1, 7, 32'h0000_00AA);
    step();
    check_val("single_not_yet", bus.cdb_en_o, 0);
    idle_all();
    step();
    check_val("single_en", bus.cdb_en_o, 1);
    check_val("single_addr", bus.cdb_reg_addr_o, 7);
    check_val("single_data", bus.cdb_data_o, 32'hAA);
    check_val("single_src", bus.cdb_src_o, 0);
    repeat (4) step();
    check_val("single_count", bc_src_q.size(), 1);
    check_val("single_hold_addr", bus.cdb_reg_addr_o, 7);

    // three simultaneous results
    clear_log();
    set_src(0, 1'b1, 3, 32'h11);
    set_src(1, 1'b1, 4, 32'h22);
    set_src(2, 1'b1, 5, 32'h33);
    step();
    idle_all();
    repeat (5) step();
    check_val("simul_count", bc_src_q.size(), 3);
`ifndef CDB_RR_ARB_EN
    if (bc_src_q.size() == 3) begin
      check_val("simul_first", bc_src_q[0], 2);
      check_val("simul_second", bc_src_q[1], 1);
      check_val("simul_third", bc_src_q[2], 0);
    end
`endif

    // MUL backpressure while LSU floods
    clear_log();
    k = 0;
    saw_low = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      set_src(1, k < 4, 10 + k, DATA_W'(32'h100 + k));
      set_src(2, cyc < 10, 20 + (cyc % 8), DATA_W'($urandom));
      if (!bus.mul_wb_ready_o) saw_low = 1'b1;
      step();
      if (last_acc[1] && k < 4) k++;
    end
    idle_all();
    repeat (4) step();
    check_val("bp_ready_dropped", saw_low, 1);
    check_val("bp_all_accepted", k, 4);
    begin
      int mul_seen [$];
      foreach (bc_src_q[i]) if (bc_src_q[i] == 1) mul_seen.push_back(bc_addr_q[i]);
      check_val("bp_mul_count", mul_seen.size(), 4);
      for (int i = 0; i < 4 && i < mul_seen.size(); i++)
        check_val($sformatf("bp_mul_order%0d", i), mul_seen[i], 10 + i);
    end

    // prd 0 is accepted and dropped
    clear_log();
    set_src(2, 1'b1, 0, 32'hDEAD);
    check_val("drop_ready", bus.lsu_wb_ready_o, 1);
    step();
    idle_all();
    repeat (4) step();
    check_val("drop_no_bc", bc_src_q.size(), 0);

    // reset with full queues
    for (int cyc = 0; cyc < 6; cyc++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (!(cur_v[s] && !last_acc[s])) begin
          cur_v[s] = 1'b1;
          cur_p[s] = PREG_W'($urandom_range(1, (1 << PREG_W) - 1));
          cur_d[s] = $urandom;
        end
      end
      drive();
      step();
    end
    do_reset(1);
    clear_log();
    repeat (5) step();
    check_val("post_rst_no_bc", bc_src_q.size(), 0);

    // random traffic
    pct = 50;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc % 60 == 0) pct = $urandom_range(10, 100);
      rand_drive(pct);
      step();
    end
    idle_all();
    repeat (8) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Collects writeback results from the ALU, MUL and LSU functional units and serialises them onto the single common data bus (CDB).
- One CDB broadcast per cycle.
- The broadcast drives rename (ready marking) and the regfile/ROB write port.
- Each FU source gets a small per-source result queue with valid/ready backpressure, so an FU stalls only when its own queue is full.

Parameters:
- PREG_W, 5: physical register address width.
- DATA_W, 32: result data width.
- QDEPTH, 2: entries per source queue; power of two, >= 2.

Ports:
- clk_i  in  1  clock, rising edge
- reset_i  in  1  synchronous, active-high reset
- alu_wb_valid_i  in  1  ALU result valid
- alu_wb_prd_i  in  PREG_W  ALU destination physical register
- alu_wb_value_i  in  DATA_W  ALU result
- alu_wb_ready_o  out  1  ALU queue can accept
- mul_wb_valid_i  in  1  MUL result valid
- mul_wb_prd_i  in  PREG_W  MUL destination physical register
- mul_wb_value_i  in  DATA_W  MUL result
- mul_wb_ready_o  out  1  MUL queue can accept
- lsu_wb_valid_i  in  1  LSU result valid
- lsu_wb_prd_i  in  PREG_W  LSU destination physical register
- lsu_wb_value_i  in  DATA_W  LSU result
- lsu_wb_ready_o  out  1  LSU queue can accept
- cdb_en_o  out  1  CDB broadcast valid this cycle
- cdb_reg_addr_o  out  PREG_W  broadcast destination
- cdb_data_o  out  DATA_W  broadcast value
- cdb_src_o  out  2  source of broadcast: 0 ALU, 1 MUL, 2 LSU

Behaviour:
- Reset (synchronous, active-high): all queues empty; cdb_en_o=0; cdb_reg_addr_o=0; cdb_data_o=0; cdb_src_o=0; all *_ready_o=1 in the cycle after reset releases. Reset mid-operation discards queued results with no broadcast.
- Handshake: a transfer occurs on a rising edge where valid_i && ready_o.
  - ready_o = (count < QDEPTH), driven from the registered count only.
  - A full queue deasserts ready_o even if it is popped that cycle. There is no same-cycle fall-through.
  - Sources must hold prd/value stable while valid_i && !ready_o.
- prd == 0: the transfer is accepted and the entry is silently dropped (never enqueued, never broadcast).
- Queue: per-source circular FIFO.
  - Read/write pointers wrap modulo QDEPTH; count is $clog2(QDEPTH)+1 bits.
  - Simultaneous push and pop on a non-full queue keeps count unchanged.
  - Order within a source is preserved.
- Arbitration: combinational over the head entries of non-empty queues each cycle.
  - Default fixed priority: LSU > MUL > ALU.
  - The winner is popped at the same edge that loads the CDB output registers.
- CDB outputs are registered:
  - cdb_en_o=1 for exactly one cycle per granted entry.
  - cdb_reg_addr_o, cdb_data_o and cdb_src_o hold their last values when cdb_en_o=0.
- Latency: a result accepted at edge E is broadcast (cdb_en_o=1) during the cycle after edge E+1, provided it wins arbitration at E+1. Minimum 2 cycles from valid-cycle to broadcast.
- Throughput: one broadcast per cycle sustained. Aggregate input above one result per cycle backpressures the losers via ready_o.
- All three queues empty: cdb_en_o=0 on the next cycle.

Optional Feature:
Macro: CDB_RR_ARB_EN.
- Defined: round-robin arbitration.
  - A 2-bit last-grant pointer (reset to ALU) makes the most recently granted source lowest priority next cycle.
  - The pointer updates only on a grant.
  - A continuously non-empty source is guaranteed a grant within 3 cycles.
- Undefined: the fixed priority LSU > MUL > ALU above, with no pointer state.

Decomposition:
- Package cdb_pkg:
  - PREG_W and DATA_W defaults.
  - Source index constants SRC_ALU=0, SRC_MUL=1, SRC_LSU=2, NUM_SRC=3.
  - Packed typedef cdb_entry_t {prd, value}.
- Sub-module cdb_src_fifo, instantiated three times: parameterised QDEPTH circular queue with push/pop/full/empty/head outputs.
- Arbiter and CDB output registers stay in cdb_arbiter.

Test Plan:
- Single ALU result: ALU prd=7, value=0x0000_00AA for 1 cycle -> cdb_en_o=1 exactly 2 cycles later with addr=7, data=0xAA, src=0; no further broadcasts.
- Simultaneous results: ALU (prd 3, 0x11), MUL (prd 4, 0x22) and LSU (prd 5, 0x33) valid in the same cycle, fixed priority -> broadcast order LSU, MUL, ALU on 3 consecutive cycles.
- Backpressure: MUL presents 4 back-to-back results (prd 10–13) while LSU floods continuously with QDEPTH=2 -> mul_wb_ready_o drops after 2 accepts; MUL results are broadcast in order 10, 11, 12, 13 once LSU stops; no result is lost or duplicated.
- prd==0 drop: LSU prd=0, value=0xDEAD -> accepted (ready stays 1); cdb_en_o stays 0.
- Reset mid-operation: reset_i asserted with all queues holding 2 entries -> next cycle cdb_en_o=0, all ready=1; no stale broadcast after reset release.
- With CDB_RR_ARB_EN, all three sources continuously valid -> grants rotate ALU, MUL, LSU, ALU, …; each source's grant gap is ≤ 3 cycles.
